neuron_packet_tx: RTL and testbench

NEURON_PACKET_TX -- requirements
Module: neuron_packet_tx

---
 rtl/neuron_packet_tx.sv | 167 ++++++++++++++++
 tb/tb_neuron_packet_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_packet_tx.sv
// Serialises neuron configuration/weight commands into a byte stream where every
// byte is held for SLOT_CYCLES cycles and strobed by load_data for HIGH_CYCLES.
module neuron_packet_tx #(
  parameter logic [7:0] MODE_CTRL        = 8'h01,
  parameter logic [7:0] MODE_ADDR_WEIGHT = 8'h02,
  parameter logic [7:0] MODE_WEIGHT      = 8'h03,
  parameter logic [7:0] END_PACKET       = 8'hFF,
  parameter int         SLOT_CYCLES      = 4,
  parameter int         HIGH_CYCLES      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [2:0]  decay_mode,
  input  logic [2:0]  init_mode_adder,
  input  logic [1:0]  adder_model,
  input  logic        init_mode_acc,
  input  logic [9:0]  address,
  input  logic [31:0] value,
  output logic [7:0]  data,
  output logic        load_data,
  output logic        busy,
  output logic        done
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);

  localparam logic [1:0] T_CTRL        = 2'd0;
  localparam logic [1:0] T_ADDR_WEIGHT = 2'd1;
  localparam logic [1:0] T_WEIGHT      = 2'd2;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state;
  logic [3:0]    byte_idx;
  logic [SW-1:0] slot_cnt;
  logic [1:0]    type_q;
  logic [7:0]    cfg0_q;
  logic [7:0]    cfg1_q;
  logic [9:0]    addr_q;
  logic [31:0]   value_q;

  logic [7:0] cfg0_in;
  logic [7:0] cfg1_in;
  logic       accept;

  assign cfg0_in   = {adder_model, init_mode_adder, decay_mode};
  assign cfg1_in   = {7'b0, init_mode_acc};
  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  // Byte at position idx of a packet of type t.
  function automatic logic [7:0] pkt_byte(input logic [1:0] t, input logic [3:0] idx,
                                          input logic [7:0] c0, input logic [7:0] c1,
                                          input logic [9:0] a, input logic [31:0] v);
    logic [7:0] b;
    b = 8'h00;
    case (t)
      T_CTRL:
        case (idx)
          4'd0:    b = MODE_CTRL;
          4'd1:    b = c0;
          4'd2:    b = c1;
          default: b = 8'h00;
        endcase
      T_ADDR_WEIGHT:
        case (idx)
          4'd0:    b = MODE_ADDR_WEIGHT;
          4'd1:    b = c0;
          4'd2:    b = c1;
          4'd3:    b = a[7:0];
          4'd4:    b = {6'b0, a[9:8]};
          4'd5:    b = v[7:0];
          4'd6:    b = v[15:8];
          4'd7:    b = v[23:16];
          4'd8:    b = v[31:24];
          default: b = 8'h00;
        endcase
      T_WEIGHT:
        case (idx)
          4'd0:    b = MODE_WEIGHT;
          4'd1:    b = c0;
          4'd2:    b = c1;
          4'd3:    b = v[7:0];
          4'd4:    b = v[15:8];
          4'd5:    b = v[23:16];
          4'd6:    b = v[31:24];
          default: b = 8'h00;
        endcase
      default: b = END_PACKET;
    endcase
    return b;
  endfunction

  function automatic logic [3:0] last_idx(input logic [1:0] t);
    case (t)
      T_CTRL:        return 4'd2;
      T_ADDR_WEIGHT: return 4'd8;
      T_WEIGHT:      return 4'd6;
      default:       return 4'd0;
    endcase
  endfunction

  // NOTE: every register here, including the captured command fields, uses
  // non-blocking assignment and is cleared by reset so an aborted packet leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      byte_idx  <= 4'd0;
      slot_cnt  <= '0;
      type_q    <= 2'd0;
      cfg0_q    <= 8'h00;
      cfg1_q    <= 8'h00;
      addr_q    <= 10'd0;
      value_q   <= 32'd0;
      data      <= 8'h00;
      load_data <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          load_data <= 1'b0;
          if (accept) begin
            // Byte 0 comes straight from the inputs so its slot starts next cycle.
            type_q    <= cmd_type;
            cfg0_q    <= cfg0_in;
            cfg1_q    <= cfg1_in;
            addr_q    <= address;
            value_q   <= value;
            data      <= pkt_byte(cmd_type, 4'd0, cfg0_in, cfg1_in, address, value);
            load_data <= 1'b1;
            busy      <= 1'b1;
            byte_idx  <= 4'd0;
            slot_cnt  <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            if (byte_idx == last_idx(type_q)) begin
              state     <= IDLE;
              byte_idx  <= 4'd0;
              busy      <= 1'b0;
              done      <= 1'b1;
              load_data <= 1'b0;
            end else begin
              byte_idx  <= byte_idx + 4'd1;
              data      <= pkt_byte(type_q, byte_idx + 4'd1, cfg0_q, cfg1_q, addr_q, value_q);
              load_data <= 1'b1;
            end
          end else begin
            slot_cnt  <= slot_cnt + 1'b1;
            load_data <= (int'(slot_cnt) + 1) < HIGH_CYCLES;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_packet_tx.sv
// Self-checking bench for neuron_packet_tx: directed cases plus random commands
// compared against a byte-queue model of each packet type.
module tb_neuron_packet_tx;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = 2'd0;
  logic [2:0]  decay_mode = 3'd0;
  logic [2:0]  init_mode_adder = 3'd0;
  logic [1:0]  adder_model = 2'd0;
  logic        init_mode_acc = 1'b0;
  logic [9:0]  address = 10'd0;
  logic [31:0] value = 32'd0;
  logic [7:0]  data;
  logic        load_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  neuron_packet_tx dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .decay_mode(decay_mode), .init_mode_adder(init_mode_adder),
    .adder_model(adder_model), .init_mode_acc(init_mode_acc), .address(address),
    .value(value), .data(data), .load_data(load_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: the packet as an ordered list of bytes.
  function automatic bq_t model(input logic [1:0] t, input logic [2:0] dm, input logic [2:0] ima,
                                input logic [1:0] am, input logic acc, input logic [9:0] a,
                                input logic [31:0] v);
    bq_t q;
    logic [7:0] c0;
    logic [7:0] c1;
    c0 = {am, ima, dm};
    c1 = {7'b0, acc};
    q = {};
    if (t == 2'd3) begin
      q.push_back(8'hFF);
    end else begin
      q.push_back(8'(t) + 8'h01);
      q.push_back(c0);
      q.push_back(c1);
      if (t == 2'd1) begin
        q.push_back(a[7:0]);
        q.push_back({6'b0, a[9:8]});
      end
      if (t != 2'd0)
        for (int k = 0; k < 4; k++) q.push_back(v[8*k +: 8]);
    end
    return q;
  endfunction

  task automatic cmp(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got data=%h ld=%b busy=%b done=%b rdy=%b, expected data=%h ld=%b busy=%b done=%b rdy=%b",
               name, act[11:4], act[3], act[2], act[1], act[0], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [11:0] outs();
    return {data, load_data, busy, done, cmd_ready};
  endfunction

  task automatic scramble_fields();
    decay_mode      = 3'($urandom);
    init_mode_adder = 3'($urandom);
    adder_model     = 2'($urandom);
    init_mode_acc   = 1'($urandom);
    address         = 10'($urandom);
    value           = $urandom;
  endtask

  // Offer a command at a negedge; returns at the negedge of the first packet cycle.
  task automatic start_cmd(input logic [1:0] t, input logic [2:0] dm, input logic [2:0] ima,
                           input logic [1:0] am, input logic acc, input logic [9:0] a,
                           input logic [31:0] v, input string name);
    @(negedge clk);
    cmd_type = t; decay_mode = dm; init_mode_adder = ima; adder_model = am;
    init_mode_acc = acc; address = a; value = v; cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready: got cmd_ready=%b expected 1", name, cmd_ready);
    end
    @(negedge clk);
  endtask

  // Checks every cycle of a packet plus its done cycle, disturbing inputs throughout.
  task automatic expect_packet(input bq_t exp, input string name, input bit hold, output int busy_cnt);
    int n;
    n = exp.size();
    busy_cnt = 0;
    for (int c = 0; c < n * 4; c++) begin
      if (c > 0) @(negedge clk);
      cmp($sformatf("%s_cyc%0d", name, c), outs(), {exp[c/4], 1'((c % 4) < 2), 1'b1, 1'b0, 1'b0});
      if (busy === 1'b1) busy_cnt++;
      scramble_fields();
      if (!hold) begin
        cmd_valid = 1'($urandom);
        cmd_type  = 2'($urandom);
      end
    end
    @(negedge clk);
    cmp($sformatf("%s_done", name), outs(), {exp[n-1], 1'b0, 1'b0, 1'b1, 1'b1});
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] t, input logic [2:0] dm, input logic [2:0] ima,
                         input logic [1:0] am, input logic acc, input logic [9:0] a,
                         input logic [31:0] v, input string name);
    bq_t exp;
    int bc;
    exp = model(t, dm, ima, am, acc, a, v);
    start_cmd(t, dm, ima, am, acc, a, v, name);
    expect_packet(exp, name, 1'b0, bc);
    checks++;
    if (bc != exp.size() * 4) begin
      failures++;
      $display("FAIL %s_busy_len: got %0d expected %0d", name, bc, exp.size() * 4);
    end
    @(negedge clk);
    cmp($sformatf("%s_after", name), outs(), {exp[exp.size()-1], 1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic test_reset();
    #2;
    cmp("reset_hold", outs(), {8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    cmp("reset_hold_clocked", outs(), {8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    #1;
    cmp("reset_release", outs(), {8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic test_ctrl();
    run_cmd(2'd0, 3'b101, 3'b010, 2'b11, 1'b1, 10'd0, 32'd0, "ctrl");
  endtask

  task automatic test_addr_weight();
    run_cmd(2'd1, 3'd0, 3'd0, 2'd0, 1'b0, 10'h2A5, 32'hDEADBEEF, "addr_weight");
  endtask

  task automatic test_end();
    run_cmd(2'd3, 3'd0, 3'd0, 2'd0, 1'b0, 10'd0, 32'd0, "end");
  endtask

  task automatic test_ignore_while_busy();
    run_cmd(2'd2, 3'b011, 3'b100, 2'b01, 1'b0, 10'h155, 32'h01020304, "weight_busy");
  endtask

  task automatic test_reset_mid_packet();
    start_cmd(2'd1, 3'd1, 3'd2, 2'd3, 1'b1, 10'h3C3, 32'h12345678, "midrst");
    cmd_valid = 1'b0;
    repeat (16) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    cmp("midrst_abort", outs(), {8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp($sformatf("midrst_hold%0d", i), outs(), {8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    rst = 1'b0;
    #1;
    cmp("midrst_release", outs(), {8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
    run_cmd(2'd0, 3'b101, 3'b010, 2'b11, 1'b1, 10'd0, 32'd0, "midrst_ctrl");
  endtask

  task automatic test_back_to_back();
    bq_t e1;
    bq_t e2;
    int bc1;
    int bc2;
    e1 = model(2'd0, 3'b110, 3'b001, 2'b10, 1'b0, 10'd0, 32'd0);
    e2 = model(2'd3, 3'd0, 3'd0, 2'd0, 1'b0, 10'd0, 32'd0);
    start_cmd(2'd0, 3'b110, 3'b001, 2'b10, 1'b0, 10'd0, 32'd0, "b2b");
    cmd_type = 2'd3;
    expect_packet(e1, "b2b_ctrl", 1'b1, bc1);
    @(negedge clk);
    expect_packet(e2, "b2b_end", 1'b1, bc2);
    cmd_valid = 1'b0;
    checks++;
    if (bc1 + bc2 != 16) begin
      failures++;
      $display("FAIL b2b_busy_total: got %0d expected 16", bc1 + bc2);
    end
    @(negedge clk);
    cmp("b2b_after", outs(), {8'hFF, 1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_cmd(2'($urandom), 3'($urandom), 3'($urandom), 2'($urandom), 1'($urandom),
              10'($urandom), $urandom, $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_addr_weight();
    test_end();
    test_ignore_while_busy();
    test_reset_mid_packet();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
